// File: rtl/decode_stage_if.sv
// decode_stage_if: bundles the fetch->decode inputs, the write-back port,
// the redirect signals returned to fetch, and the D/E pipeline register
// outputs of decode_stage.
//   master : the surrounding core (drives fetch/W inputs, consumes outputs)
//   slave  : decode_stage itself
interface decode_stage_if;
   // fetch -> decode
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   // write-back port
   logic        RegWriteW;
   logic [4:0]  RdW;
   logic [31:0] ResultW;
   // redirect back to fetch (combinational)
   logic        PCSrcD;
   logic        JalD;
   logic [31:0] PCTargetD;
   // D/E register
   logic        RegWriteE;
   logic        MemWriteE;
   logic        MemReadE;
   logic        ALUSrcE;
   logic        ALUSrcAE;
   logic [1:0]  ResultSrcE;
   logic [3:0]  ALUControlE;
   logic [2:0]  Funct3E;
   logic [31:0] RD1E;
   logic [31:0] RD2E;
   logic [31:0] ImmExtE;
   logic [31:0] PCE;
   logic [31:0] PCPlus4E;
   logic [4:0]  Rs1E;
   logic [4:0]  Rs2E;
   logic [4:0]  RdE;
   logic        IllegalE;

   modport master (
      output InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW,
      input  PCSrcD, JalD, PCTargetD,
      input  RegWriteE, MemWriteE, MemReadE, ALUSrcE, ALUSrcAE, ResultSrcE,
      input  ALUControlE, Funct3E, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
      input  Rs1E, Rs2E, RdE, IllegalE
   );

   modport slave (
      input  InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW,
      output PCSrcD, JalD, PCTargetD,
      output RegWriteE, MemWriteE, MemReadE, ALUSrcE, ALUSrcAE, ResultSrcE,
      output ALUControlE, Funct3E, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
      output Rs1E, Rs2E, RdE, IllegalE
   );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage. Decodes InstrD, reads the 32x32
// register file (write-first against the W stage), builds the immediate,
// resolves branches/jumps (PCSrcD/JalD/PCTargetD back to fetch) and holds
// the D/E pipeline register. A squash counter turns the SQUASH_DEPTH
// wrong-path instructions after a redirect into bubbles.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   d   : decode_stage_if.slave (fetch inputs, W port, redirect, E outputs)
module decode_stage #(
   parameter int unsigned SQUASH_DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst,
   decode_stage_if.slave d
);
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;
   localparam logic [3:0] ALU_PASS = 4'd10;

   localparam logic [1:0] SQ_LOAD = 2'(SQUASH_DEPTH);

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic        mem_read;
      logic        alu_src;
      logic        alu_src_a;
      logic [1:0]  result_src;
      logic [3:0]  alu_ctrl;
      logic [2:0]  funct3;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        illegal;
   } de_t;

   function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt_sub,
                                          input logic alt_sra);
      case (f3)
         3'b000:  alu_sel = alt_sub ? ALU_SUB : ALU_ADD;
         3'b001:  alu_sel = ALU_SLL;
         3'b010:  alu_sel = ALU_SLT;
         3'b011:  alu_sel = ALU_SLTU;
         3'b100:  alu_sel = ALU_XOR;
         3'b101:  alu_sel = alt_sra ? ALU_SRA : ALU_SRL;
         3'b110:  alu_sel = ALU_OR;
         default: alu_sel = ALU_AND;
      endcase
   endfunction

   logic [31:0] rf_q [32];
   logic [31:0] rf_d [32];
   logic [1:0]  sq_q, sq_d;
   de_t         de_q, de_d, dec;

   logic [31:0] instr;
   logic [4:0]  rs1, rs2;
   logic [31:0] rd1, rd2;
   logic        wr_en, squash, is_branch, is_jal, is_jalr, cond;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign instr  = d.InstrD;
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign wr_en  = d.RegWriteW && (d.RdW != 5'd0);
   assign squash = (sq_q != 2'd0);

   // write-first read: a same-cycle W write to rs wins over the stored value
   assign rd1 = (rs1 == 5'd0) ? '0 : (wr_en && d.RdW == rs1) ? d.ResultW : rf_q[rs1];
   assign rd2 = (rs2 == 5'd0) ? '0 : (wr_en && d.RdW == rs2) ? d.ResultW : rf_q[rs2];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   always_comb begin
      rf_d = rf_q;
      if (wr_en) rf_d[d.RdW] = d.ResultW;
   end

   always_comb begin
      dec          = '0;
      dec.funct3   = instr[14:12];
      dec.rd1      = rd1;
      dec.rd2      = rd2;
      dec.pc       = d.PCD;
      dec.pc_plus4 = d.PCPlus4D;
      dec.rs1      = rs1;
      dec.rs2      = rs2;
      is_branch    = 1'b0;
      is_jal       = 1'b0;
      is_jalr      = 1'b0;
      case (instr[6:0])
         OP_LUI:    begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_ctrl = ALU_PASS; dec.imm = imm_u; end
         OP_AUIPC:  begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_src_a = 1'b1; dec.imm = imm_u; end
         OP_JAL:    begin dec.reg_write = 1'b1; dec.result_src = 2'b10; dec.imm = imm_j; is_jal = 1'b1; end
         OP_JALR:   begin
            dec.reg_write = 1'b1; dec.result_src = 2'b10; dec.alu_src = 1'b1;
            dec.imm = imm_i; is_jalr = 1'b1;
         end
         OP_BRANCH: begin dec.imm = imm_b; is_branch = 1'b1; end
         OP_LOAD:   begin
            dec.reg_write = 1'b1; dec.mem_read = 1'b1; dec.result_src = 2'b01;
            dec.alu_src = 1'b1; dec.imm = imm_i;
         end
         OP_STORE:  begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; dec.imm = imm_s; end
         OP_IMM:    begin
            dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.imm = imm_i;
            dec.alu_ctrl  = alu_sel(instr[14:12], 1'b0, instr[30]);
         end
         OP_OP:     begin
            dec.reg_write = 1'b1;
            dec.alu_ctrl  = alu_sel(instr[14:12], instr[30], instr[30]);
         end
         OP_FENCE, OP_SYSTEM: dec.imm = imm_i;
         default:   dec.illegal = 1'b1;
      endcase
      // non-writing instructions carry rd=0 so E never sees a false destination
      dec.rd = dec.reg_write ? instr[11:7] : '0;
   end

   always_comb begin
      case (instr[14:12])
         3'b000:  cond = (rd1 == rd2);
         3'b001:  cond = (rd1 != rd2);
         3'b100:  cond = ($signed(rd1) < $signed(rd2));
         3'b101:  cond = ($signed(rd1) >= $signed(rd2));
         3'b110:  cond = (rd1 < rd2);
         3'b111:  cond = (rd1 >= rd2);
         default: cond = 1'b0;
      endcase
   end

   assign d.PCSrcD    = is_branch & cond & ~squash;
   assign d.JalD      = (is_jal | is_jalr) & ~squash;
   assign d.PCTargetD = is_jalr ? ((rd1 + dec.imm) & ~32'd1) : (d.PCD + dec.imm);

   // a redirect only arms the counter when not already squashing, so a jump
   // inside the window is ignored (it is gated off above anyway)
   always_comb begin
      sq_d = sq_q;
      if (squash)                    sq_d = sq_q - 2'd1;
      else if (d.PCSrcD || d.JalD)   sq_d = SQ_LOAD;
   end

   always_comb begin
      de_d = dec;
      if (squash) begin
         de_d.reg_write  = 1'b0;
         de_d.mem_write  = 1'b0;
         de_d.mem_read   = 1'b0;
         de_d.alu_src    = 1'b0;
         de_d.alu_src_a  = 1'b0;
         de_d.result_src = '0;
         de_d.alu_ctrl   = ALU_ADD;
         de_d.rd         = '0;
         de_d.illegal    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
         sq_q <= '0;
         de_q <= '0;
      end else begin
         rf_q <= rf_d;
         sq_q <= sq_d;
         de_q <= de_d;
      end
   end

   assign d.RegWriteE   = de_q.reg_write;
   assign d.MemWriteE   = de_q.mem_write;
   assign d.MemReadE    = de_q.mem_read;
   assign d.ALUSrcE     = de_q.alu_src;
   assign d.ALUSrcAE    = de_q.alu_src_a;
   assign d.ResultSrcE  = de_q.result_src;
   assign d.ALUControlE = de_q.alu_ctrl;
   assign d.Funct3E     = de_q.funct3;
   assign d.RD1E        = de_q.rd1;
   assign d.RD2E        = de_q.rd2;
   assign d.ImmExtE     = de_q.imm;
   assign d.PCE         = de_q.pc;
   assign d.PCPlus4E    = de_q.pc_plus4;
   assign d.Rs1E        = de_q.rs1;
   assign d.Rs2E        = de_q.rs2;
   assign d.RdE         = de_q.rd;
   assign d.IllegalE    = de_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed-vector scoreboard bench for decode_stage.
// Stimulus pushes the hand-computed E-stage expectation for each issued
// instruction; a monitor pops one entry per clock and compares E outputs.
// Combinational redirect outputs are checked directly by the stimulus.
module tb_decode_stage;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   decode_stage_if bus ();
   decode_stage #(.SQUASH_DEPTH(2)) dut (.clk(clk), .rst(rst), .d(bus));

   typedef struct {
      logic [16:0] ctl;
      bit          ci;
      logic [31:0] imm;
      bit          cr;
      logic [31:0] rd1;
      bit          cp;
      logic [31:0] pc4;
   } exp_t;

   exp_t sb[$];
   exp_t me;
   int   n_tests = 0;
   int   n_fail  = 0;

   localparam logic [31:0] FENCE = 32'h0000000F;
   localparam logic [16:0] BUB   = 17'd0;

   // {RegWrite, MemWrite, MemRead, ALUSrc, ALUSrcA, ResultSrc, ALUControl, Illegal, Rd}
   function automatic logic [16:0] ctl(input logic rw, mw, mr, as, asa, input logic [1:0] rs,
                                       input logic [3:0] alu, input logic ill, input logic [4:0] rd);
      return {rw, mw, mr, as, asa, rs, alu, ill, rd};
   endfunction

   function automatic exp_t mk(input logic [16:0] c, input bit ci, input logic [31:0] imm,
                               input bit cr, input logic [31:0] rd1, input bit cp, input logic [31:0] pc4);
      exp_t e;
      e.ctl = c; e.ci = ci; e.imm = imm; e.cr = cr; e.rd1 = rd1; e.cp = cp; e.pc4 = pc4;
      return e;
   endfunction

   function automatic exp_t e0(input logic [16:0] c);
      return mk(c, 0, '0, 0, '0, 0, '0);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, expv, $time);
      end
   endtask

   function automatic logic [16:0] act_ctl();
      return {bus.RegWriteE, bus.MemWriteE, bus.MemReadE, bus.ALUSrcE, bus.ALUSrcAE,
              bus.ResultSrcE, bus.ALUControlE, bus.IllegalE, bus.RdE};
   endfunction

   task automatic chk_e_zero(input string nm);
      chk({nm, "_ctl"}, {15'd0, act_ctl()}, 32'd0);
      chk({nm, "_pce"}, bus.PCE, 32'd0);
      chk({nm, "_pcp4e"}, bus.PCPlus4E, 32'd0);
      chk({nm, "_rd1e"}, bus.RD1E | bus.RD2E, 32'd0);
      chk({nm, "_imme"}, bus.ImmExtE, 32'd0);
   endtask

   task automatic apply(input logic [31:0] instr, input logic [31:0] pc, input logic wen,
                        input logic [4:0] rdw, input logic [31:0] resw, input exp_t e);
      @(posedge clk);
      #1;
      bus.InstrD    = instr;
      bus.PCD       = pc;
      bus.PCPlus4D  = pc + 32'd4;
      bus.RegWriteW = wen;
      bus.RdW       = rdw;
      bus.ResultW   = resw;
      #2;
      sb.push_back(e);
   endtask

   task automatic chk_redir(input string nm, input logic src, input logic jal, input logic [31:0] tgt,
                            input bit ct);
      chk({nm, "_pcsrc"}, {31'd0, bus.PCSrcD}, {31'd0, src});
      chk({nm, "_jal"}, {31'd0, bus.JalD}, {31'd0, jal});
      if (ct) chk({nm, "_target"}, bus.PCTargetD, tgt);
   endtask

   // monitor: E register updates on each edge; compare against the oldest expectation
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (sb.size() > 0) begin
            me = sb.pop_front();
            chk("e_ctl", {15'd0, act_ctl()}, {15'd0, me.ctl});
            if (me.ci) chk("e_imm", bus.ImmExtE, me.imm);
            if (me.cr) chk("e_rd1", bus.RD1E, me.rd1);
            if (me.cp) chk("e_pcplus4", bus.PCPlus4E, me.pc4);
         end
      end
   end

   initial begin
      rst = 1'b1;
      bus.InstrD = '0; bus.PCD = '0; bus.PCPlus4D = '0;
      bus.RegWriteW = 1'b0; bus.RdW = '0; bus.ResultW = '0;
      #12;
      chk_e_zero("init_rst");
      @(posedge clk);
      #1 rst = 1'b0;

      apply(32'h0, 32'h0, 0, 0, 0, e0(ctl(0,0,0,0,0,0,0,1,0)));
      apply(32'h00500093, 32'h4, 0, 0, 0, mk(ctl(1,0,0,1,0,0,0,0,1), 1, 32'd5, 0, 0, 0, 0));
      apply(32'h00018233, 32'h8, 1, 5'd3, 32'hDEADBEEF,
            mk(ctl(1,0,0,0,0,0,0,0,4), 0, 0, 1, 32'hDEADBEEF, 0, 0));
      apply(32'h00000233, 32'hC, 1, 5'd0, 32'h12345678,
            mk(ctl(1,0,0,0,0,0,0,0,4), 0, 0, 1, 32'h0, 0, 0));

      apply(32'h00000463, 32'h10, 0, 0, 0, mk(BUB, 1, 32'd8, 0, 0, 0, 0));
      chk_redir("beq", 1, 0, 32'h18, 1);
      apply(32'h010000EF, 32'h14, 0, 0, 0, e0(BUB));
      chk_redir("jal_in_window", 0, 0, 0, 0);
      apply(32'h00500093, 32'h18, 0, 0, 0, e0(BUB));
      chk_redir("addi_in_window", 0, 0, 0, 0);
      apply(32'h00700113, 32'h1C, 0, 0, 0, mk(ctl(1,0,0,1,0,0,0,0,2), 1, 32'd7, 0, 0, 0, 0));

      apply(32'h010000EF, 32'h20, 0, 0, 0,
            mk(ctl(1,0,0,0,0,2'b10,0,0,1), 1, 32'd16, 0, 0, 1, 32'h24));
      chk_redir("jal", 0, 1, 32'h30, 1);
      apply(32'h00000463, 32'h24, 0, 0, 0, e0(BUB));
      chk_redir("beq_in_window", 0, 0, 0, 0);
      apply(FENCE, 32'h28, 0, 0, 0, e0(BUB));

      apply(32'h00001417, 32'h30, 0, 0, 0, mk(ctl(1,0,0,1,1,0,0,0,8), 1, 32'h1000, 0, 0, 0, 0));
      apply(32'h402084B3, 32'h34, 0, 0, 0, e0(ctl(1,0,0,0,0,0,4'd1,0,9)));
      apply(32'h00402503, 32'h38, 0, 0, 0, mk(ctl(1,0,1,1,0,2'b01,0,0,10), 1, 32'd4, 0, 0, 0, 0));

      apply(FENCE, 32'h3C, 1, 5'd5, 32'h00001001, e0(BUB));
      apply(FENCE, 32'h3C, 1, 5'd6, 32'hFFFFFFFF, e0(BUB));
      apply(FENCE, 32'h3C, 1, 5'd7, 32'h00000001, e0(BUB));

      apply(32'h00328067, 32'h40, 0, 0, 0,
            mk(ctl(1,0,0,1,0,2'b10,0,0,0), 1, 32'd3, 1, 32'h1001, 1, 32'h44));
      chk_redir("jalr", 0, 1, 32'h1004, 1);
      apply(FENCE, 32'h44, 0, 0, 0, e0(BUB));
      apply(FENCE, 32'h48, 0, 0, 0, e0(BUB));
      apply(32'h00529463, 32'h4C, 0, 0, 0, mk(BUB, 1, 32'd8, 1, 32'h1001, 0, 0));
      chk_redir("bne_equal", 0, 0, 0, 0);
      apply(32'h00734463, 32'h50, 0, 0, 0, mk(BUB, 1, 32'd8, 1, 32'hFFFFFFFF, 0, 0));
      chk_redir("blt_signed", 1, 0, 32'h58, 1);
      apply(FENCE, 32'h54, 0, 0, 0, e0(BUB));
      apply(FENCE, 32'h58, 0, 0, 0, e0(BUB));
      apply(32'h00736463, 32'h5C, 0, 0, 0, e0(BUB));
      chk_redir("bltu_unsigned", 0, 0, 0, 0);

      // arm the squash window, then reset while sq==1
      apply(32'h00000463, 32'h60, 0, 0, 0, e0(BUB));
      chk_redir("beq_pre_rst", 1, 0, 32'h68, 1);
      apply(FENCE, 32'h64, 0, 0, 0, e0(BUB));
      @(posedge clk);
      #3;
      rst = 1'b1;
      sb.delete();
      #1;
      chk_e_zero("mid_squash_rst");
      @(posedge clk);
      #1 rst = 1'b0;

      apply(32'h00018233, 32'h0, 0, 0, 0, mk(ctl(1,0,0,0,0,0,0,0,4), 0, 0, 1, 32'h0, 0, 0));
      apply(32'h00000463, 32'h10, 0, 0, 0, e0(BUB));
      chk_redir("beq_after_rst", 1, 0, 32'h18, 1);
      apply(FENCE, 32'h14, 0, 0, 0, e0(BUB));
      apply(FENCE, 32'h18, 0, 0, 0, e0(BUB));
      apply(32'hFFFFFFFF, 32'h1C, 0, 0, 0, e0(ctl(0,0,0,0,0,0,0,1,0)));
      apply(FENCE, 32'h20, 0, 0, 0, e0(BUB));

      repeat (2) @(posedge clk);
      #4;
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
